// File: rtl/elevator_call_scheduler.sv
// Latches hall/cab calls per floor and runs a SCAN sweep FSM that publishes one registered target.
// Optional macro FLOOR_LOCKOUT_EN adds a floor_lockout input that takes floors out of service.
module elevator_call_scheduler #(
   parameter int NUM_FLOORS = 6,
   parameter int FLOOR_W    = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] up_call,
   input  logic [NUM_FLOORS-1:0] down_call,
   input  logic [NUM_FLOORS-1:0] cab_call,
   input  logic [FLOOR_W-1:0]    cur_floor,
   input  logic                  serve_valid,
   input  logic [FLOOR_W-1:0]    serve_floor,
   input  logic                  serve_dir_up,
   output logic [NUM_FLOORS-1:0] pending_up,
   output logic [NUM_FLOORS-1:0] pending_down,
   output logic [NUM_FLOORS-1:0] pending_cab,
   output logic                  target_valid,
   output logic [FLOOR_W-1:0]    target_floor,
   output logic                  target_dir_up,
   output logic                  any_pending
`ifdef FLOOR_LOCKOUT_EN
   ,
   input  logic [NUM_FLOORS-1:0] floor_lockout
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

   // No up call exists at the top floor and no down call at the bottom floor.
   localparam logic [NUM_FLOORS-1:0] UP_OK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
   localparam logic [NUM_FLOORS-1:0] DN_OK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

   logic [NUM_FLOORS-1:0] elig;
`ifdef FLOOR_LOCKOUT_EN
   assign elig = ~floor_lockout;
`else
   assign elig = '1;
`endif

   state_t                state, state_nxt;
   logic [NUM_FLOORS-1:0] clr_up, clr_down, clr_cab;
   logic [NUM_FLOORS-1:0] up_nxt, down_nxt, cab_nxt;
   logic [NUM_FLOORS-1:0] cu, cd, all_p;
   logic                  valid_nxt, dir_nxt;
   logic [FLOOR_W-1:0]    floor_nxt;
   logic                  cur_ok, at_all, at_up, at_cu, at_cd;
   logic                  ua_f, ub_f, da_f, db_f, na_f, nb_f;
   logic                  up_has, dn_has, go_up;
   int                    cur_i, ua, ub, da, db, na, nb, up_tgt, dn_tgt;

   // Clear beats a same-cycle call because it is applied after the OR.
   always_comb begin
      clr_up   = '0;
      clr_down = '0;
      clr_cab  = '0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
         if (serve_valid && int'(serve_floor) == f) begin
            clr_cab[f]  = 1'b1;
            clr_up[f]   = serve_dir_up;
            clr_down[f] = ~serve_dir_up;
         end
      end
      up_nxt   = (pending_up   | (up_call   & UP_OK)) & ~clr_up   & elig;
      down_nxt = (pending_down | (down_call & DN_OK)) & ~clr_down & elig;
      cab_nxt  = (pending_cab  | cab_call)            & ~clr_cab  & elig;
   end

   assign any_pending = |{pending_up, pending_down, pending_cab};

   always_comb begin
      cur_i  = int'(cur_floor);
      cur_ok = cur_i < NUM_FLOORS;
      cu     = (pending_cab | pending_up)   & elig;
      cd     = (pending_cab | pending_down) & elig;
      all_p  = cu | cd;
      at_all = 1'b0;
      at_up  = 1'b0;
      at_cu  = 1'b0;
      at_cd  = 1'b0;
      ua_f = 1'b0; ub_f = 1'b0; da_f = 1'b0; db_f = 1'b0; na_f = 1'b0; nb_f = 1'b0;
      ua = 0; ub = 0; da = 0; db = 0; na = 0; nb = 0;
      // Ascending scan: the last hit is the highest matching floor.
      for (int f = 0; f < NUM_FLOORS; f++) begin
         if (f == cur_i) begin
            at_all = all_p[f];
            at_up  = pending_up[f] & elig[f];
            at_cu  = cu[f];
            at_cd  = cd[f];
         end
         if (f > cur_i && pending_down[f] && elig[f]) begin ub_f = 1'b1; ub = f; end
         if (f < cur_i && cd[f])                      begin da_f = 1'b1; da = f; end
         if (f < cur_i && all_p[f])                   begin nb_f = 1'b1; nb = f; end
      end
      // Descending scan: the last hit is the lowest matching floor.
      for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
         if (f > cur_i && cu[f])                      begin ua_f = 1'b1; ua = f; end
         if (f < cur_i && pending_up[f] && elig[f])   begin db_f = 1'b1; db = f; end
         if (f > cur_i && all_p[f])                   begin na_f = 1'b1; na = f; end
      end
      up_has = ua_f | ub_f;
      dn_has = da_f | db_f;
      up_tgt = ua_f ? ua : ub;
      dn_tgt = da_f ? da : db;
      go_up  = na_f && (!nb_f || (na - cur_i) <= (cur_i - nb));
   end

   always_comb begin
      state_nxt = state;
      valid_nxt = 1'b0;
      floor_nxt = target_floor;
      dir_nxt   = target_dir_up;
      if (!cur_ok) begin
         state_nxt = state;
      end else if (all_p == '0) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               valid_nxt = 1'b1;
               if (at_all) begin
                  floor_nxt = cur_floor;
                  dir_nxt   = at_up;
               end else if (go_up) begin
                  state_nxt = S_UP;
                  floor_nxt = FLOOR_W'(up_tgt);
                  dir_nxt   = 1'b1;
               end else begin
                  state_nxt = S_DOWN;
                  floor_nxt = FLOOR_W'(dn_tgt);
                  dir_nxt   = 1'b0;
               end
            end
            S_UP: begin
               dir_nxt = 1'b1;
               if (at_cu) begin
                  valid_nxt = 1'b1;
                  floor_nxt = cur_floor;
               end else if (up_has) begin
                  valid_nxt = 1'b1;
                  floor_nxt = FLOOR_W'(up_tgt);
               end else if (nb_f) begin
                  state_nxt = S_DOWN;
                  dir_nxt   = 1'b0;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
            S_DOWN: begin
               dir_nxt = 1'b0;
               if (at_cd) begin
                  valid_nxt = 1'b1;
                  floor_nxt = cur_floor;
               end else if (dn_has) begin
                  valid_nxt = 1'b1;
                  floor_nxt = FLOOR_W'(dn_tgt);
               end else if (na_f) begin
                  state_nxt = S_UP;
                  dir_nxt   = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         pending_up    <= '0;
         pending_down  <= '0;
         pending_cab   <= '0;
         target_valid  <= 1'b0;
         target_floor  <= '0;
         target_dir_up <= 1'b1;
      end else begin
         state         <= state_nxt;
         pending_up    <= up_nxt;
         pending_down  <= down_nxt;
         pending_cab   <= cab_nxt;
         target_valid  <= valid_nxt;
         target_floor  <= floor_nxt;
         target_dir_up <= dir_nxt;
      end
   end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler (NUM_FLOORS=6); lockout scenario under FLOOR_LOCKOUT_EN.
`timescale 1ns/1ps
module tb_elevator_call_scheduler;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] up_call = '0, down_call = '0, cab_call = '0;
   logic [2:0] cur_floor = '0, serve_floor = '0;
   logic       serve_valid = 1'b0, serve_dir_up = 1'b0;
   logic [5:0] pending_up, pending_down, pending_cab;
   logic       target_valid, target_dir_up, any_pending;
   logic [2:0] target_floor;
`ifdef FLOOR_LOCKOUT_EN
   logic [5:0] floor_lockout = '0;
`endif
   int n_cmp = 0;
   int n_bad = 0;

   elevator_call_scheduler #(.NUM_FLOORS(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .up_call(up_call), .down_call(down_call), .cab_call(cab_call),
      .cur_floor(cur_floor), .serve_valid(serve_valid), .serve_floor(serve_floor),
      .serve_dir_up(serve_dir_up),
      .pending_up(pending_up), .pending_down(pending_down), .pending_cab(pending_cab),
      .target_valid(target_valid), .target_floor(target_floor),
      .target_dir_up(target_dir_up), .any_pending(any_pending)
`ifdef FLOOR_LOCKOUT_EN
      , .floor_lockout(floor_lockout)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      up_call = '0; down_call = '0; cab_call = '0;
      serve_valid = 1'b0; serve_floor = '0; serve_dir_up = 1'b0; cur_floor = '0;
`ifdef FLOOR_LOCKOUT_EN
      floor_lockout = '0;
`endif
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      n_cmp++; if (pending_up !== 6'b0) begin n_bad++; $display("FAIL reset_pup got %b exp 000000", pending_up); end
      n_cmp++; if (pending_cab !== 6'b0) begin n_bad++; $display("FAIL reset_pcab got %b exp 000000", pending_cab); end
      n_cmp++; if (target_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", target_valid); end
      n_cmp++; if (target_floor !== 3'd0) begin n_bad++; $display("FAIL reset_floor got %0d exp 0", target_floor); end
      n_cmp++; if (target_dir_up !== 1'b1) begin n_bad++; $display("FAIL reset_dir got %b exp 1", target_dir_up); end
      n_cmp++; if (any_pending !== 1'b0) begin n_bad++; $display("FAIL reset_any got %b exp 0", any_pending); end
   endtask

   task automatic test_single_cab();
      do_reset();
      cab_call = 6'b001000;
      tick();
      cab_call = '0;
      n_cmp++; if (pending_cab !== 6'b001000) begin n_bad++; $display("FAIL cab_latch got %b exp 001000", pending_cab); end
      n_cmp++; if (any_pending !== 1'b1) begin n_bad++; $display("FAIL cab_any got %b exp 1", any_pending); end
      n_cmp++; if (target_valid !== 1'b0) begin n_bad++; $display("FAIL cab_lat_valid got %b exp 0", target_valid); end
      tick();
      n_cmp++; if ({target_valid, target_dir_up, target_floor} !== {1'b1, 1'b1, 3'd3})
         begin n_bad++; $display("FAIL cab_target got v=%b d=%b f=%0d exp v=1 d=1 f=3", target_valid, target_dir_up, target_floor); end
      serve_valid = 1'b1; serve_floor = 3'd3; serve_dir_up = 1'b1;
      tick();
      serve_valid = 1'b0;
      n_cmp++; if (pending_cab !== 6'b0) begin n_bad++; $display("FAIL cab_clear got %b exp 000000", pending_cab); end
      tick();
      n_cmp++; if (target_valid !== 1'b0) begin n_bad++; $display("FAIL cab_done_valid got %b exp 0", target_valid); end
   endtask

   task automatic test_sweep();
      do_reset();
      cur_floor = 3'd2;
      cab_call = 6'b010000;
      tick();
      cab_call = '0;
      tick();
      down_call = 6'b100000; up_call = 6'b000010;
      tick();
      down_call = '0; up_call = '0;
      tick();
      n_cmp++; if ({target_valid, target_dir_up, target_floor} !== {1'b1, 1'b1, 3'd4})
         begin n_bad++; $display("FAIL sweep_t4 got v=%b d=%b f=%0d exp v=1 d=1 f=4", target_valid, target_dir_up, target_floor); end
      serve_valid = 1'b1; serve_floor = 3'd4; serve_dir_up = 1'b1;
      tick();
      serve_valid = 1'b0;
      tick();
      n_cmp++; if ({target_valid, target_dir_up, target_floor} !== {1'b1, 1'b1, 3'd5})
         begin n_bad++; $display("FAIL sweep_t5 got v=%b d=%b f=%0d exp v=1 d=1 f=5", target_valid, target_dir_up, target_floor); end
      serve_valid = 1'b1; serve_floor = 3'd5; serve_dir_up = 1'b0;
      tick();
      serve_valid = 1'b0;
      n_cmp++; if (pending_down !== 6'b0) begin n_bad++; $display("FAIL sweep_pdown got %b exp 000000", pending_down); end
      tick();
      n_cmp++; if (target_valid !== 1'b0) begin n_bad++; $display("FAIL sweep_reversal got v=%b exp 0", target_valid); end
      tick();
      n_cmp++; if ({target_valid, target_dir_up, target_floor} !== {1'b1, 1'b0, 3'd1})
         begin n_bad++; $display("FAIL sweep_t1 got v=%b d=%b f=%0d exp v=1 d=0 f=1", target_valid, target_dir_up, target_floor); end
   endtask

   task automatic test_reset_mid_sweep();
      n_cmp++; if (any_pending !== 1'b1) begin n_bad++; $display("FAIL mid_pre_any got %b exp 1", any_pending); end
      rst_n = 1'b0;
      #2;
      n_cmp++; if (pending_up !== 6'b0) begin n_bad++; $display("FAIL mid_pup got %b exp 000000", pending_up); end
      n_cmp++; if ({target_valid, target_dir_up, target_floor} !== {1'b0, 1'b1, 3'd0})
         begin n_bad++; $display("FAIL mid_target got v=%b d=%b f=%0d exp v=0 d=1 f=0", target_valid, target_dir_up, target_floor); end
      n_cmp++; if (any_pending !== 1'b0) begin n_bad++; $display("FAIL mid_any got %b exp 0", any_pending); end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_same_cycle_clear();
      do_reset();
      up_call = 6'b001000; down_call = 6'b001000;
      serve_valid = 1'b1; serve_floor = 3'd3; serve_dir_up = 1'b1;
      tick();
      up_call = '0; down_call = '0; serve_valid = 1'b0;
      n_cmp++; if (pending_up !== 6'b0) begin n_bad++; $display("FAIL clr_wins got %b exp 000000", pending_up); end
      n_cmp++; if (pending_down !== 6'b001000) begin n_bad++; $display("FAIL clr_keep_down got %b exp 001000", pending_down); end
   endtask

   task automatic test_ignored();
      do_reset();
      up_call = 6'b100000; down_call = 6'b000001;
      tick();
      up_call = '0; down_call = '0;
      n_cmp++; if ({pending_up, pending_down} !== 12'b0) begin n_bad++; $display("FAIL ign_edges got %b/%b exp 0/0", pending_up, pending_down); end
      n_cmp++; if (any_pending !== 1'b0) begin n_bad++; $display("FAIL ign_any got %b exp 0", any_pending); end
      cab_call = 6'b000100;
      tick();
      cab_call = '0;
      serve_valid = 1'b1; serve_floor = 3'd7; serve_dir_up = 1'b0;
      tick();
      serve_valid = 1'b0;
      n_cmp++; if (pending_cab !== 6'b000100) begin n_bad++; $display("FAIL ign_serve7 got %b exp 000100", pending_cab); end
   endtask

   task automatic test_idle_at_cur();
      do_reset();
      cur_floor = 3'd3;
      cab_call = 6'b001000;
      tick();
      cab_call = '0;
      tick();
      n_cmp++; if ({target_valid, target_dir_up, target_floor} !== {1'b1, 1'b0, 3'd3})
         begin n_bad++; $display("FAIL at_cur got v=%b d=%b f=%0d exp v=1 d=0 f=3", target_valid, target_dir_up, target_floor); end
   endtask

   task automatic test_equal_distance();
      do_reset();
      cur_floor = 3'd2;
      cab_call = 6'b010001;
      tick();
      cab_call = '0;
      tick();
      n_cmp++; if ({target_valid, target_dir_up, target_floor} !== {1'b1, 1'b1, 3'd4})
         begin n_bad++; $display("FAIL tie_up got v=%b d=%b f=%0d exp v=1 d=1 f=4", target_valid, target_dir_up, target_floor); end
   endtask

   task automatic test_cur_out_of_range();
      do_reset();
      cur_floor = 3'd6;
      cab_call = 6'b000010;
      tick();
      cab_call = '0;
      tick();
      n_cmp++; if (pending_cab !== 6'b000010) begin n_bad++; $display("FAIL oor_latch got %b exp 000010", pending_cab); end
      n_cmp++; if (target_valid !== 1'b0) begin n_bad++; $display("FAIL oor_valid got %b exp 0", target_valid); end
      cur_floor = 3'd0;
      tick();
      n_cmp++; if ({target_valid, target_dir_up, target_floor} !== {1'b1, 1'b1, 3'd1})
         begin n_bad++; $display("FAIL oor_recover got v=%b d=%b f=%0d exp v=1 d=1 f=1", target_valid, target_dir_up, target_floor); end
   endtask

`ifdef FLOOR_LOCKOUT_EN
   task automatic test_lockout();
      do_reset();
      cab_call = 6'b010000;
      tick();
      cab_call = '0;
      n_cmp++; if (pending_cab !== 6'b010000) begin n_bad++; $display("FAIL lock_pre got %b exp 010000", pending_cab); end
      floor_lockout = 6'b010000;
      tick();
      n_cmp++; if (pending_cab !== 6'b0) begin n_bad++; $display("FAIL lock_clear got %b exp 000000", pending_cab); end
      cab_call = 6'b010000;
      tick();
      tick();
      cab_call = '0;
      n_cmp++; if (pending_cab !== 6'b0) begin n_bad++; $display("FAIL lock_nolatch got %b exp 000000", pending_cab); end
      n_cmp++; if (target_valid !== 1'b0) begin n_bad++; $display("FAIL lock_notarget got %b exp 0", target_valid); end
      floor_lockout = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_single_cab();
      test_sweep();
      test_reset_mid_sweep();
      test_same_cycle_clear();
      test_ignored();
      test_idle_at_cur();
      test_equal_distance();
      test_cur_out_of_range();
`ifdef FLOOR_LOCKOUT_EN
      test_lockout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
